match_ctrl: RTL and testbench

//  Match sequencer for pong: drives the ball block's reset/start, detects a missed ball from its x position,

---
 rtl/pong_pkg.sv | 32 +++
 rtl/serve_timer.sv | 41 ++++
 rtl/match_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_match_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// Module : pong_pkg
// Brief  : Shared types and widths for the pong match sequencer.
//          match_state_e : match sequencer states
//          player_e      : player identity (also the winner output encoding)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int X_W     = 10;  // ball x coordinate width
  localparam int SCORE_W = 4;   // per-player score width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } match_state_e;

  typedef enum logic [1:0] {
    P_NONE = 2'b00,
    P1     = 2'b01,
    P2     = 2'b10
  } player_e;

endpackage

`default_nettype wire

// File: rtl/serve_timer.sv
// ============================================================================
// Module : serve_timer
// Brief  : Loadable down-counter that times the serve delay.
// Ports  : clk      in  clock
//          reset    in  synchronous active-high reset (count -> 0)
//          load     in  load load_val (takes priority over dec)
//          load_val in  W  value to load
//          dec      in  decrement by one, saturating at zero
//          zero     out count is zero
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serve_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/match_ctrl.sv
// ============================================================================
// Module : match_ctrl
// Brief  : Pong match sequencer. Drives the ball block reset/start, detects a
//          missed ball from its x position, keeps both scores, times the serve
//          delay, handles pause/resume and declares the winner.
// Ports  : clk        in   game-tick clock (shared with the ball block)
//          reset      in   synchronous active-high reset
//          play_btn   in   one-cycle pulse: start / pause / resume / rematch
//          ball_x     in   10  ball x_min from the ball block
//          ball_reset out  hold ball at its serve position
//          ball_start out  ball moves while high
//          score1     out  4   player 1 (left paddle) score
//          score2     out  4   player 2 (right paddle) score
//          game_over  out  high while a winner is declared
//          winner     out  2   01 = P1, 10 = P2, 00 = none
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module match_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_WIDTH = 640,
  parameter int BALL_LEN     = 15,
  parameter int EDGE_MARGIN  = 64,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_DELAY  = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_btn,
  input  logic [X_W-1:0]     ball_x,
  output logic               ball_reset,
  output logic               ball_start,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [1:0]         winner
);

  // $clog2(1) is 0, so a zero delay still gets a one-bit counter.
  localparam int CNT_W = (SERVE_DELAY == 0) ? 1 : $clog2(SERVE_DELAY + 1);

  localparam logic [X_W-1:0] LEFT_LIM  = X_W'((2 ** X_W) - EDGE_MARGIN);
  localparam logic [X_W:0]   RIGHT_LIM = (X_W + 1)'(SCREEN_WIDTH);
  localparam logic [X_W:0]   BALL_EXT  = (X_W + 1)'(BALL_LEN);
  localparam logic [SCORE_W:0] WIN_VAL = (SCORE_W + 1)'(WIN_SCORE);

  match_state_e state, next_state;
  player_e      scorer, next_scorer;
  player_e      winner_q;

  logic timer_load, timer_dec, timer_zero;
  logic inc1, inc2, clear_match, set_winner;
  logic miss_left, miss_right;
  logic [SCORE_W:0] score1_p1, score2_p1;

  // --------------------------------------------------------------------------
  // Miss decode. A ball that slips past x=0 wraps to a large x value, so the
  // top EDGE_MARGIN codes are a left miss; the right check uses an 11-bit sum
  // so the far edge cannot wrap. Masking with !miss_left keeps them exclusive.
  // --------------------------------------------------------------------------
  assign miss_left  = (ball_x >= LEFT_LIM);
  assign miss_right = (({1'b0, ball_x} + BALL_EXT) >= RIGHT_LIM) && !miss_left;

  assign score1_p1 = {1'b0, score1} + 1'b1;
  assign score2_p1 = {1'b0, score2} + 1'b1;

  serve_timer #(
    .W (CNT_W)
  ) u_serve_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (CNT_W'(SERVE_DELAY)),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // --------------------------------------------------------------------------
  // State register and match registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      scorer    <= P_NONE;
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
      winner_q  <= P_NONE;
    end else begin
      state  <= next_state;
      scorer <= next_scorer;
      if (clear_match) begin
        score1    <= '0;
        score2    <= '0;
        game_over <= 1'b0;
        winner_q  <= P_NONE;
      end else begin
        if (inc1) score1 <= score1_p1[SCORE_W-1:0];
        if (inc2) score2 <= score2_p1[SCORE_W-1:0];
        if (set_winner) begin
          winner_q  <= scorer;
          game_over <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    next_scorer = scorer;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    inc1        = 1'b0;
    inc2        = 1'b0;
    clear_match = 1'b0;
    set_winner  = 1'b0;

    case (state)
      S_IDLE: begin
        if (play_btn) begin
          next_state = S_SERVE;
          timer_load = 1'b1;
        end
      end

      S_SERVE: begin
        if (timer_zero) next_state = S_PLAY;
        else            timer_dec  = 1'b1;
      end

      S_PLAY: begin
        // A miss outranks the button: the point is taken, the press dropped.
        if (miss_left) begin
          next_state  = S_POINT;
          next_scorer = P2;
        end else if (miss_right) begin
          next_state  = S_POINT;
          next_scorer = P1;
        end else if (play_btn) begin
          next_state = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (play_btn) next_state = S_PLAY;
      end

      S_POINT: begin
        inc1 = (scorer == P1);
        inc2 = (scorer == P2);
        if ((inc1 && (score1_p1 == WIN_VAL)) || (inc2 && (score2_p1 == WIN_VAL))) begin
          next_state = S_OVER;
          set_winner = 1'b1;
        end else begin
          next_state = S_SERVE;
          timer_load = 1'b1;
        end
      end

      S_OVER: begin
        if (play_btn) begin
          next_state  = S_SERVE;
          timer_load  = 1'b1;
          clear_match = 1'b1;
        end
      end

      default: begin
        next_state  = S_IDLE;
        next_scorer = P_NONE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  assign ball_start = (state == S_PLAY);
  assign ball_reset = !((state == S_PLAY) || (state == S_PAUSE));
  assign winner     = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_match_ctrl.sv
// ============================================================================
// Module : tb_match_ctrl
// Brief  : Self-checking bench for match_ctrl (SERVE_DELAY=3, WIN_SCORE=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_btn = 1'b0;
  logic [9:0] ball_x = 10'd100;
  logic       ball_reset, ball_start, game_over;
  logic [3:0] score1, score2;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  match_ctrl #(
    .SCREEN_WIDTH (640),
    .BALL_LEN     (15),
    .EDGE_MARGIN  (64),
    .WIN_SCORE    (2),
    .SERVE_DELAY  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_btn   (play_btn),
    .ball_x     (ball_x),
    .ball_reset (ball_reset),
    .ball_start (ball_start),
    .score1     (score1),
    .score2     (score2),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [9:0] x;
    logic       br;
    logic       bs;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic [1:0] w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic btn, input logic [9:0] x, input logic br, input logic bs,
                     input logic [3:0] s1, input logic [3:0] s2, input logic go,
                     input logic [1:0] w);
    vec_t v;
    v.btn = btn; v.x = x; v.br = br; v.bs = bs;
    v.s1 = s1; v.s2 = s2; v.go = go; v.w = w;
    vecs.push_back(v);
  endtask

  // Apply inputs for one clock and sample outputs just after the edge.
  task automatic tick(input logic btn, input logic [9:0] x);
    @(negedge clk);
    play_btn = btn;
    ball_x   = x;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got br/bs/s1/s2/go/w=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {ball_reset, ball_start, score1, score2, game_over, winner};
  endfunction

  function automatic logic [12:0] pack(input logic br, input logic bs, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic go,
                                       input logic [1:0] w);
    return {br, bs, s1, s2, go, w};
  endfunction

  task automatic wait_serve(input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1'b0, 10'd100);
      seen = ball_start;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s ball_start never rose got 0 expected 1", name);
    end
  endtask

  initial begin
    //  btn  x     br bs s1 s2 go w
    add(1, 100,   1, 0, 0, 0, 0, 0);  // 0  IDLE -> SERVE
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 1
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 2
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 3
    add(0, 100,   0, 1, 0, 0, 0, 0);  // 4  serve released
    add(0, 100,   0, 1, 0, 0, 0, 0);  // 5  mid-field, no score
    add(0, 630,   1, 0, 0, 0, 0, 0);  // 6  right miss -> POINT
    add(0, 630,   1, 0, 1, 0, 0, 0);  // 7  P1 scores
    add(0, 100,   1, 0, 1, 0, 0, 0);  // 8
    add(0, 100,   1, 0, 1, 0, 0, 0);  // 9
    add(0, 100,   1, 0, 1, 0, 0, 0);  // 10
    add(0, 100,   0, 1, 1, 0, 0, 0);  // 11 replay
    add(0, 1020,  1, 0, 1, 0, 0, 0);  // 12 left miss (wrapped)
    add(0, 100,   1, 0, 1, 1, 0, 0);  // 13 P2 scores
    add(0, 100,   1, 0, 1, 1, 0, 0);  // 14
    add(0, 100,   1, 0, 1, 1, 0, 0);  // 15
    add(0, 100,   1, 0, 1, 1, 0, 0);  // 16
    add(0, 100,   0, 1, 1, 1, 0, 0);  // 17
    add(1, 100,   0, 0, 1, 1, 0, 0);  // 18 pause
    add(0, 630,   0, 0, 1, 1, 0, 0);  // 19 miss ignored while paused
    add(0, 630,   0, 0, 1, 1, 0, 0);  // 20
    add(1, 630,   0, 1, 1, 1, 0, 0);  // 21 resume
    add(0, 630,   1, 0, 1, 1, 0, 0);  // 22 miss -> POINT
    add(0, 100,   1, 0, 2, 1, 1, 1);  // 23 P1 wins
    add(0, 100,   1, 0, 2, 1, 1, 1);  // 24 held
    add(0, 1020,  1, 0, 2, 1, 1, 1);  // 25 no scoring in OVER
    add(1, 100,   1, 0, 0, 0, 0, 0);  // 26 rematch
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 27
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 28
    add(0, 100,   1, 0, 0, 0, 0, 0);  // 29
    add(0, 100,   0, 1, 0, 0, 0, 0);  // 30
    add(1, 1020,  1, 0, 0, 0, 0, 0);  // 31 miss + button: point wins
    add(0, 100,   1, 0, 0, 1, 0, 0);  // 32 P2 scores, back to SERVE

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), pack(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].btn, vecs[i].x);
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].br, vecs[i].bs, vecs[i].s1, vecs[i].s2, vecs[i].go, vecs[i].w));
    end

    // Reset mid-countdown (state is SERVE here).
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_serve", outs(), pack(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick(1'b0, 10'd100);
    check("idle_holds", outs(), pack(1, 0, 0, 0, 0, 0));

    // P2 takes two points and the match.
    tick(1'b1, 10'd100);
    wait_serve("serve_a");
    tick(1'b0, 10'd1020);
    tick(1'b0, 10'd100);
    check("p2_first", outs(), pack(1, 0, 0, 1, 0, 0));
    wait_serve("serve_b");
    tick(1'b0, 10'd1020);
    tick(1'b0, 10'd100);
    check("p2_wins", outs(), pack(1, 0, 0, 2, 1, 2));
    repeat (3) tick(1'b0, 10'd1020);
    check("over_frozen", outs(), pack(1, 0, 0, 2, 1, 2));
    tick(1'b1, 10'd100);
    check("rematch_clear", outs(), pack(1, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
